// File: rtl/usb_adc_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : usb_adc_stream                                                |
// | Purpose  : N-channel ADC sample serializer into a byte FIFO, released to |
// |            the USB controller as fixed-size bulk IN packets with rewind  |
// |            on unacknowledged transfers. Commands come in on a bulk OUT   |
// |            endpoint.                                                     |
// | Options  : ADC_STREAM_HEADER_EN - prefix each packet with 0xA5, seq[7:0] |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module usb_adc_stream #(
  parameter int CH        = 1,
  parameter int DW        = 8,
  parameter int FIFO_AW   = 11,
  parameter int PKT_BYTES = 512,
  parameter int EP_IN     = 2,
  parameter int EP_OUT    = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             adc_vld_i,
  input  logic [CH*DW-1:0] adc_dat_i,
  input  logic [3:0]       endpt_i,
  input  logic             txact_i,
  input  logic             txpop_i,
  output logic [7:0]       txdat_o,
  output logic             txval_o,
  output logic [11:0]      txdat_len_o,
  output logic             txcork_o,
  input  logic             rxact_i,
  input  logic             rxval_i,
  input  logic [7:0]       rxdat_i,
  output logic             rxrdy_o,
  output logic             running_o,
  output logic             overflow_o
);

  localparam int BPS   = (DW <= 8) ? 1 : 2;
  localparam int FB    = CH * BPS;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = $clog2(FB + 1);
  localparam int PW    = 11;
`ifdef ADC_STREAM_HEADER_EN
  localparam int HDR   = 2;
`else
  localparam int HDR   = 0;
`endif
  localparam int PAYLOAD = PKT_BYTES - HDR;
  localparam logic [FIFO_AW:0] PAYLOAD_W = (FIFO_AW + 1)'(PAYLOAD);
  localparam logic [FIFO_AW:0] ROOM_LIM  = (FIFO_AW + 1)'(DEPTH - FB);
  localparam logic [PW-1:0]    PKT_W     = PW'(PKT_BYTES);

  typedef enum logic [1:0] {IDLE, ARMED, SEND, CHECK} state_t;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, cmt_ptr, snap_ptr;
  logic [FB*8-1:0]  frame_bytes, shift;
  logic [LW-1:0]    left;
  logic             running, overflow, rdy, cork;
  logic [6:0]       decim, dcnt;
  logic [PW-1:0]    pops;
  state_t           state;
`ifdef ADC_STREAM_HEADER_EN
  logic [7:0]       seq;
`endif

  // Zero-extend each channel to its byte lane(s); little-endian when two bytes
  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign frame_bytes[c*BPS*8 +: BPS*8] = (BPS*8)'(adc_dat_i[c*DW +: DW]);
  end

  logic cmd_hit, cmd_start, in_match, busy, strobe_ok, do_frame, room_short;
  logic accept, drop;
  logic [FIFO_AW:0] used;

  assign cmd_hit    = rxact_i & rxval_i & (endpt_i == 4'(EP_OUT));
  assign cmd_start  = cmd_hit & (rxdat_i == 8'h01);
  assign in_match   = (endpt_i == 4'(EP_IN));
  assign busy       = (left != '0);
  // A start command in the same cycle as a strobe swallows the strobe
  assign strobe_ok  = adc_vld_i & running & ~cmd_start;
  assign do_frame   = strobe_ok & (dcnt == 7'd0);
  // Free space is measured against the committed read pointer so that
  // bytes of a packet awaiting acknowledgement are never overwritten.
  assign used       = wr_ptr - cmt_ptr;
  assign room_short = (used > ROOM_LIM);
  assign accept     = do_frame & ~busy & ~room_short;
  assign drop       = do_frame & (busy | room_short);

  // Serializer: latch a whole frame, then emit one byte per cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      left   <= '0;
      shift  <= '0;
      wr_ptr <= '0;
    end else if (accept) begin
      shift <= frame_bytes;
      left  <= LW'(FB);
    end else if (busy) begin
      shift  <= shift >> 8;
      left   <= left - 1'b1;
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // FIFO storage; flushing is done by resetting the pointers
  always_ff @(posedge clk_i) begin
    if (busy) mem[wr_ptr[FIFO_AW-1:0]] <= shift[7:0];
  end

  // Command decode, decimation counter and sticky overflow flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdy      <= 1'b0;
      running  <= 1'b0;
      overflow <= 1'b0;
      decim    <= '0;
      dcnt     <= '0;
    end else begin
      rdy <= 1'b1;
      if (cmd_hit) begin
        case (rxdat_i)
          8'h00: running <= 1'b0;
          8'h01: begin
            running <= 1'b1;
            dcnt    <= '0;
          end
          8'h02: overflow <= 1'b0;
          default: if (rxdat_i[7]) decim <= rxdat_i[6:0];
        endcase
      end
      if (strobe_ok) dcnt <= (dcnt >= decim) ? 7'd0 : dcnt + 7'd1;
      if (drop) overflow <= 1'b1;
    end
  end

  // IN packet state machine with snapshot/rewind on incomplete transfers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      cork     <= 1'b1;
      rd_ptr   <= '0;
      cmt_ptr  <= '0;
      snap_ptr <= '0;
      pops     <= '0;
`ifdef ADC_STREAM_HEADER_EN
      seq      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cork <= 1'b1;
          if (used >= PAYLOAD_W) begin
            state <= ARMED;
            cork  <= 1'b0;
          end
        end
        ARMED: begin
          if (txact_i && in_match) begin
            state    <= SEND;
            snap_ptr <= rd_ptr;
            pops     <= '0;
          end
        end
        SEND: begin
          cork <= 1'b1;
          if (!txact_i) begin
            state <= CHECK;
          end else if (txpop_i && in_match && (pops < PKT_W)) begin
            pops <= pops + 1'b1;
            if (int'(pops) >= HDR) rd_ptr <= rd_ptr + 1'b1;
          end
        end
        default: begin
          if (pops == PKT_W) begin
            cmt_ptr <= rd_ptr;
`ifdef ADC_STREAM_HEADER_EN
            seq     <= seq + 8'd1;
`endif
            state   <= IDLE;
          end else begin
            rd_ptr <= snap_ptr;
            cork   <= 1'b0;
            state  <= ARMED;
          end
        end
      endcase
    end
  end

  logic [7:0] out_byte;
  // First-word-fall-through byte selection, with optional header injection
  always_comb begin
    out_byte = mem[rd_ptr[FIFO_AW-1:0]];
`ifdef ADC_STREAM_HEADER_EN
    if (pops == '0)        out_byte = 8'hA5;
    else if (pops == 'd1)  out_byte = seq;
`endif
  end

  assign txval_o     = (state == SEND) & txact_i & in_match;
  assign txdat_o     = (state == SEND) ? out_byte : 8'h00;
  assign txdat_len_o = 12'(PKT_BYTES);
  assign txcork_o    = cork;
  assign rxrdy_o     = rdy;
  assign running_o   = running;
  assign overflow_o  = overflow;

endmodule
`default_nettype wire

// File: doc/usb_adc_stream.md
# usb_adc_stream

Parametrised ADC-to-USB bulk streaming engine that sits between the ADC front end and `USB_Device_Controller_Top` in the `PHY_CLKOUT` domain. It generalises the single-channel 8-bit path to N channels of up to 16-bit samples, with a byte FIFO and sample decimation. Fixed-size IN packets are released only when a full packet is buffered, and unacknowledged packets are rewound for retry. Start, stop, decimation and overflow-clear commands arrive as bytes on a bulk OUT endpoint.

## Interface
Parameters:
- `CH`, 1: channel count, 1..8.
- `DW`, 8: sample width, 1..16. Bytes per sample `BPS` = 1 if `DW`≤8, else 2.
- `FIFO_AW`, 11: byte FIFO address width; 2^`FIFO_AW` ≥ 2·`PKT_BYTES`.
- `PKT_BYTES`, 512: IN packet length in bytes, ≤ 1024.
- `EP_IN`, 2: IN endpoint number.
- `EP_OUT`, 2: OUT endpoint number.

Ports:
- `clk_i`  in  1  clock (`PHY_CLKOUT`); the only clock.
- `reset_i`  in  1  reset; synchronous, active-high.
- `adc_vld_i`  in  1  one-cycle frame strobe, already synchronous to `clk_i`.
- `adc_dat_i`  in  `CH`·`DW`  channel samples; channel 0 in the LSBs.
- `endpt_i`  in  4  endpoint selected by the controller.
- `txact_i`  in  1  IN transaction active.
- `txpop_i`  in  1  controller consumes `txdat_o`.
- `txdat_o`  out  8  IN data byte.
- `txval_o`  out  1  `txdat_o` is valid.
- `txdat_len_o`  out  12  packet length; constant `PKT_BYTES`.
- `txcork_o`  out  1  1 = NAK IN requests.
- `rxact_i`  in  1  OUT transaction active.
- `rxval_i`  in  1  `rxdat_i` is valid.
- `rxdat_i`  in  8  OUT data byte.
- `rxrdy_o`  out  1  ready to accept OUT data.
- `running_o`  out  1  capture is enabled.
- `overflow_o`  out  1  sticky: a frame was dropped.

## Operation
- **Capture.** When `adc_vld_i`=1, `running_o`=1 and the decimation counter is 0:
  - `adc_dat_i` is latched.
  - The serializer writes `CH`·`BPS` bytes into the FIFO, one byte per cycle, in order ch0..chN-1.
  - Each sample is zero-extended. When `BPS`=2 it is written little-endian.
- **Decimation counter.** Counts 0..`decim`, wrapping to 0, and advances on each `adc_vld_i` while running.
- **Frame drop.** The whole frame is dropped and `overflow_o` is set if either condition holds at the strobe:
  - free FIFO space < `CH`·`BPS`;
  - the serializer is still busy.
  - Frames are never partially written.
- **IN state machine** (states IDLE, ARMED, SEND, CHECK):
  - IDLE → ARMED when committed FIFO count ≥ payload bytes. `txcork_o` goes 0 in ARMED.
  - ARMED → SEND when `txact_i`=1 and `endpt_i`=`EP_IN`. The read-pointer snapshot and the pop count are taken at this transition.
  - In SEND, `txval_o` = `txact_i` & endpoint match. Each `txpop_i` advances the read pointer; `txdat_o` shows the next byte (FWFT).
  - SEND → CHECK on `txact_i` falling.
  - CHECK: if the pop count = `PKT_BYTES`, commit the read pointer, increment `seq`, and go to IDLE. Otherwise rewind to the snapshot and go to ARMED.
- **Commands** (each `rxval_i` byte when `endpt_i`=`EP_OUT`):
  - 0x00: stop.
  - 0x01: start; clears the decimation counter.
  - 0x02: clear `overflow_o`.
  - 1xxxxxxx: `decim` = bits[6:0].
  - Other values are ignored.
  - `rxrdy_o` = 1 except during reset.
- **Stop.** Data already in the FIFO is still drained. A frame mid-serialization completes.

## Timing
- Reset values:
  - `txdat_o` 0, `txval_o` 0, `txcork_o` 1, `txdat_len_o` `PKT_BYTES`.
  - `rxrdy_o` 0, `running_o` 0, `overflow_o` 0.
  - FIFO empty, `decim` 0, `seq` 0, state IDLE.
- Strobe to first FIFO byte write: 1 cycle. The last byte is written at cycle `CH`·`BPS`. Bytes become visible to the committed count the cycle after they are written.
- Minimum strobe spacing: `CH`·`BPS`+1 cycles. A strobe arriving earlier is dropped.
- `txcork_o` falls 1 cycle after the threshold is reached. It rises in the cycle after entry to SEND and stays 1 until ARMED is re-entered.
- A FIFO write and an IN pop in the same cycle are both honoured.
- A command byte takes effect on the next cycle. A start and a strobe in the same cycle: the strobe is ignored.
- `reset_i` mid-packet: all state is reset immediately and the FIFO is flushed.

## Configuration
- `ADC_STREAM_HEADER_EN` defined:
  - Each packet is 0xA5, `seq`[7:0], then `PKT_BYTES`−2 payload bytes. The header is injected by the state machine and not stored in the FIFO.
  - `seq` increments only on commit, so a retried packet repeats the same `seq`.
- Undefined: payload = `PKT_BYTES`, no header.

## Test plan
- CH=2, DW=12, PKT_BYTES=8, start, 2 strobes with ch0=0x123, ch1=0xABC → one packet 23 01 BC 0A 23 01 BC 0A; `txcork_o` 0 only after the 8th byte is written.
- Command 0x83, 8 strobes → exactly 2 frames captured (strobes 1 and 5).
- Abort: txact falls after 3 pops → next IN transaction replays an identical packet (same `seq` with header enabled); FIFO count unchanged until commit.
- No host reads, 2^`FIFO_AW`/(`CH`·`BPS`)+1 strobes → `overflow_o`=1, FIFO holds only whole frames; command 0x02 → `overflow_o`=0.
- Strobe spacing `CH`·`BPS` cycles → every second frame dropped, `overflow_o`=1.
- `reset_i` asserted mid-SEND → next cycle `txcork_o`=1, `txval_o`=0, `running_o`=0, FIFO empty.
